fraction_multiplier_n: RTL

FRACTION_MULTIPLIER_N -- requirements
Module: fraction_multiplier_n

---
 rtl/fraction_mul_pkg.sv | 14 +
 rtl/frac_mul_addsub.sv | 33 +++
 rtl/fraction_multiplier_n.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fraction_mul_pkg.sv
// Shared types and constants for the signed fraction multiplier.
// FSM state encoding and the default operand width live here.
package fraction_mul_pkg;

   localparam int FMUL_N_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_SUB  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/frac_mul_addsub.sv
// Sign-extending (N+1)-bit add/subtract of the partial product and MC.
// i_en=0 passes the sign-extended partial product straight through.
module frac_mul_addsub
   import fraction_mul_pkg::*;
#(
   parameter int N = FMUL_N_DEF
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_mc,
   input  logic         i_en,
   input  logic         i_sub,
   output logic [N:0]   o_sum
);

   logic [N:0] w_a;
   logic [N:0] w_mc;
   logic [N:0] w_op;

   assign w_a  = {i_a[N-1], i_a};
   assign w_mc = {i_mc[N-1], i_mc};

   // Sign bit of the multiplier carries negative weight, hence the subtract.
   always_comb begin
      w_op = '0;
      if (i_en) begin
         if (i_sub) w_op = ~w_mc + (N+1)'(1);
         else       w_op = w_mc;
      end
   end

   assign o_sum = w_a + w_op;

endmodule

// File: rtl/fraction_multiplier_n.sv
// Sequential add-shift multiplier for Q1.(N-1) signed fractions.
// Define FRAC_MUL_SAT_EN to saturate -1 x -1 and raise Ovf.
module fraction_multiplier_n
   import fraction_mul_pkg::*;
#(
   parameter int N = FMUL_N_DEF
) (
   input  logic           CLK,
   input  logic           Rst,
   input  logic           St,
   input  logic [N-1:0]   Mplier,
   input  logic [N-1:0]   Mcand,
   output logic [2*N-2:0] Product,
   output logic           Done,
   output logic           Busy,
   output logic           Ovf
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N-2);

   state_t           r_state;
   state_t           w_next;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic [N-1:0]     r_mc;
   logic [CW-1:0]    r_cnt;
   logic [2*N-2:0]   r_prod;
   logic             r_done;
   logic [N:0]       w_sum;
   logic             w_sub;
   logic             w_shift;

   assign w_sub   = (r_state == S_SUB);
   assign w_shift = (r_state == S_ADD) || (r_state == S_SUB);

   frac_mul_addsub #(.N(N)) u_addsub (
      .i_a   (r_a),
      .i_mc  (r_mc),
      .i_en  (r_b[0]),
      .i_sub (w_sub),
      .o_sum (w_sum)
   );

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (St) w_next = S_ADD;
         S_ADD:  if (r_cnt == LAST) w_next = S_SUB;
         S_SUB:  w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_mc  <= '0;
         r_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         if (St) begin
            r_a   <= '0;
            r_b   <= Mplier;
            r_mc  <= Mcand;
            r_cnt <= '0;
         end
      end else if (w_shift) begin
         r_a <= w_sum[N:1];
         r_b <= {w_sum[0], r_b[N-1:1]};
         if (r_state == S_ADD && r_cnt != LAST)
            r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) r_done <= 1'b0;
      else     r_done <= (r_state == S_DONE);
   end

`ifdef FRAC_MUL_SAT_EN
   localparam logic [N-1:0]   MINV = {1'b1, {(N-1){1'b0}}};
   localparam logic [2*N-2:0] MAXP = {1'b0, {(2*N-2){1'b1}}};

   logic r_neg1;
   logic r_ovf;

   // B is shifted away during the operation, so remember -1 x -1 at start.
   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         r_neg1 <= 1'b0;
      end else if (r_state == S_IDLE && St) begin
         r_neg1 <= (Mplier == MINV) && (Mcand == MINV);
      end
   end

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         r_prod <= '0;
         r_ovf  <= 1'b0;
      end else if (r_state == S_DONE) begin
         if (r_neg1) begin
            r_prod <= MAXP;
            r_ovf  <= 1'b1;
         end else begin
            r_prod <= {r_a[N-2:0], r_b};
            r_ovf  <= 1'b0;
         end
      end
   end

   assign Ovf = r_ovf;
`else
   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst)                    r_prod <= '0;
      else if (r_state == S_DONE) r_prod <= {r_a[N-2:0], r_b};
   end

   assign Ovf = 1'b0;
`endif

   assign Product = r_prod;
   assign Done    = r_done;
   assign Busy    = (r_state != S_IDLE);

endmodule
